// File: rtl/enemy_draw_scheduler.sv
// rtl/enemy_draw_scheduler.sv - walks the enemy formation once per frame and sequences the sprite renderer
module enemy_draw_scheduler #(
    parameter int ROWS           = 4,
    parameter int COLS           = 8,
    parameter int X_SPACING      = 32,
    parameter int Y_SPACING      = 24,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 frame_start,
    input  logic [8:0]           origin_x,
    input  logic [7:0]           origin_y,
    input  logic [ROWS*COLS-1:0] alive,
    input  logic                 sprite_done,
    output logic                 sprite_enable,
    output logic [8:0]           sprite_x,
    output logic [7:0]           sprite_y,
    output logic                 busy,
    output logic                 frame_done,
    output logic [5:0]           drawn_count,
    output logic                 timeout_err
);
    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [5:0]    LAST_IDX = 6'(N - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [N-1:0]  ONE_HOT0 = N'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_FINISH
    } state_t;

    state_t        state, next_state;
    logic [N-1:0]  alive_snap;
    logic [8:0]    ox;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [5:0]    idx;
    logic [TW-1:0] tcnt;
    logic          cur_alive, is_last, accept, got_done, timed_out, leave_wait, advance;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (frame_start) next_state = S_SCAN;
            S_SCAN:   if (cur_alive)   next_state = S_ISSUE;
                      else if (is_last) next_state = S_FINISH;
            S_ISSUE:  next_state = S_WAIT;
            S_WAIT:   if (leave_wait)  next_state = is_last ? S_FINISH : S_SCAN;
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // A done coinciding with the final wait cycle wins over the timeout.
    always_comb begin
        cur_alive  = |(alive_snap & (ONE_HOT0 << idx));
        is_last    = (idx == LAST_IDX);
        accept     = (state == S_IDLE) && frame_start;
        got_done   = (state == S_WAIT) && sprite_done;
        timed_out  = (state == S_WAIT) && !sprite_done && (tcnt == TO_LAST);
        leave_wait = got_done || timed_out;
        advance    = ((state == S_SCAN) && !cur_alive && !is_last) || (leave_wait && !is_last);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sprite_enable <= 1'b0;
            sprite_x      <= '0;
            sprite_y      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            drawn_count   <= '0;
            timeout_err   <= 1'b0;
            alive_snap    <= '0;
            ox            <= '0;
            row           <= '0;
            col           <= '0;
            idx           <= '0;
            tcnt          <= '0;
        end else begin
            sprite_enable <= (state == S_SCAN) && cur_alive;
            frame_done    <= (state == S_FINISH);
            if (state == S_FINISH) busy <= 1'b0;
            if (accept) begin
                alive_snap  <= alive;
                ox          <= origin_x;
                sprite_x    <= origin_x;
                sprite_y    <= origin_y;
                row         <= '0;
                col         <= '0;
                idx         <= '0;
                drawn_count <= '0;
                timeout_err <= 1'b0;
                busy        <= 1'b1;
            end
            if (state == S_ISSUE)     tcnt <= '0;
            else if (state == S_WAIT) tcnt <= tcnt + TW'(1);
            if (got_done)  drawn_count <= drawn_count + 6'd1;
            if (timed_out) timeout_err <= 1'b1;
            // Positions are accumulated so no multiplier is needed.
            if (advance) begin
                idx <= idx + 6'd1;
                if (col != LAST_COL) begin
                    col      <= col + CW'(1);
                    sprite_x <= sprite_x + 9'(X_SPACING);
                end else begin
                    col      <= '0;
                    row      <= row + RW'(1);
                    sprite_x <= ox;
                    sprite_y <= sprite_y + 8'(Y_SPACING);
                end
            end
        end
    end
endmodule

// File: doc/enemy_draw_scheduler.md
Name: enemy_draw_scheduler

Overview:
Sequences the enemy sprite renderer across the whole enemy formation once per frame. On `frame_start` it walks a ROWS×COLS grid. For each live enemy it computes the screen position, pulses the renderer's `enable` for one cycle and waits for its `done`. It sits between the game-logic block (formation origin, alive mask) and the enemy sprite FSM, which drives the VGA adapter.

Parameters:
- ROWS, 4, formation rows.
- COLS, 8, formation columns.
- X_SPACING, 32, horizontal pixel pitch between columns (must exceed sprite width 28).
- Y_SPACING, 24, vertical pixel pitch between rows (must exceed sprite height 20).
- TIMEOUT_CYCLES, 1023, maximum cycles to wait for `sprite_done` per enemy.

Ports:
- `clk`  in  1  system clock
- `resetn`  in  1  asynchronous active-low reset
- `frame_start`  in  1  request one formation draw; sampled only in IDLE
- `origin_x`  in  9  formation top-left X; latched at accepted `frame_start`
- `origin_y`  in  8  formation top-left Y; latched at accepted `frame_start`
- `alive`  in  ROWS*COLS  live mask; bit index = row*COLS+col; latched at accepted `frame_start`
- `sprite_done`  in  1  one-cycle done from the enemy sprite FSM
- `sprite_enable`  out  1  one-cycle start pulse to the enemy sprite FSM
- `sprite_x`  out  9  X position to the sprite FSM
- `sprite_y`  out  8  Y position to the sprite FSM
- `busy`  out  1  high from accepted `frame_start` until FINISH completes
- `frame_done`  out  1  one-cycle pulse when the formation pass ends
- `drawn_count`  out  6  enemies drawn in current/last pass (sized for ROWS*COLS ≤ 63)
- `timeout_err`  out  1  sticky; set on any per-enemy timeout; cleared at next accepted `frame_start`

Behaviour:
- Single clock `clk`. Reset `resetn` is asynchronous and active-low.
- Reset values: state IDLE; `sprite_enable`, `sprite_x`, `sprite_y`, `busy`, `frame_done`, `drawn_count` and `timeout_err` all 0; internal row, col, idx and timeout counters all 0.
- States: IDLE, SCAN, ISSUE, WAIT_DONE, FINISH.
- IDLE:
  - `busy`=0.
  - `frame_start`=1 → latch origin and alive snapshot; row=col=idx=0; `drawn_count`=0; `timeout_err`=0; `sprite_x`=`origin_x`; `sprite_y`=`origin_y`; go to SCAN.
- SCAN (examines one index per cycle):
  - `alive_snap[idx]`=1 → ISSUE.
  - Otherwise, if idx is the last index (ROWS*COLS-1) → FINISH.
  - Otherwise advance position → SCAN.
- ISSUE: `sprite_enable`=1 for exactly this cycle; zero timeout counter; → WAIT_DONE.
- WAIT_DONE:
  - `sprite_enable`=0; `sprite_x`/`sprite_y` held stable.
  - `sprite_done`=1 → `drawn_count`+1; then advance, or go to FINISH if last index.
  - Timeout counter reaches TIMEOUT_CYCLES → set `timeout_err`; `drawn_count` unchanged; advance or FINISH as above.
- FINISH: `frame_done`=1 for one cycle; → IDLE. `busy` drops entering IDLE.
- Advance rule:
  - col<COLS-1: col+1; idx+1; `sprite_x`+=X_SPACING.
  - col=COLS-1: col=0; row+1; idx+1; `sprite_x`=`origin_x`; `sprite_y`+=Y_SPACING.
- Arithmetic: 9-bit/8-bit modulo add. No clamping; wrap at 512 (X) and 256 (Y) is accepted.
- Multipliers and dividers are not used; positions are accumulated.
- `frame_start` while `busy` is ignored; no queuing.
- Changes to `alive` or origin mid-pass are ignored (snapshot).
- `sprite_done` outside WAIT_DONE is ignored.
- A done that arrives in the same cycle the timeout hits counts as done; `timeout_err` is not set.
- Reset asserted mid-pass: immediate return to IDLE with reset values. The sprite FSM is reset by the same `resetn`.
- Throughput per live enemy: ISSUE + WAIT_DONE + 1 SCAN cycle beyond the renderer's latency.

Test Plan:
- Reset: assert `resetn`=0 mid-WAIT_DONE → all outputs 0 asynchronously; state IDLE; `frame_start` after release starts a clean pass.
- All dead: `alive`=0, `frame_start` pulse → `frame_done` high exactly 33 cycles after the sampling edge; `sprite_enable` never high; `drawn_count`=0.
- Positions: origin (40,20), `alive` bits 0, 9 and 31 set → enables in order with (x,y) = (40,20), (72,44), (264,92); `drawn_count`=3; one `frame_done`.
- Handshake: sprite-FSM model returns done 562 cycles after enable → each enable is one cycle; the next enable does not appear before the previous done; x/y stable throughout the wait.
- Timeout: model never returns done for bit 9 → `timeout_err`=1 after 1023 wait cycles; pass continues to bit 31; `drawn_count`=2. The next `frame_start` clears `timeout_err`.
- Ignored inputs: `frame_start` pulsed and `alive` changed mid-pass → no restart; drawn set matches the original snapshot.
